// File: rtl/uart_rx_frame_engine_pkg.sv
// rtl/uart_rx_frame_engine_pkg.sv - shared types and constants for the UART RX frame engine
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int MIN_PRESC = 4;
  localparam int MIN_LEN   = 5;

  // Frame-format flags latched at start of frame.
  typedef struct packed {
    logic par_en;
    logic par_odd;
    logic stop2;
  } rx_cfg_t;

endpackage

// File: rtl/uart_rx_frame_engine_if.sv
// rtl/uart_rx_frame_engine_if.sv - frame delivery bundle from the RX engine to the FIFO/register side
interface uart_rx_frame_engine_if #(
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              par_err;
  logic              frm_err;
  logic              start_glitch;
  logic              break_det;
  logic              busy;

  modport master (
    output p_data, data_valid, par_err, frm_err, start_glitch, break_det, busy
  );

  modport slave (
    input  p_data, data_valid, par_err, frm_err, start_glitch, break_det, busy
  );
endinterface

// File: rtl/uart_rx_frame_engine_sampler.sv
// rtl/uart_rx_frame_engine_sampler.sv - 3-tap majority voter for one oversampled bit
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic tap_en,
  input  logic dec_en,
  output logic vote,
  output logic vote_valid
);
  logic [2:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (tap_en) taps_d = {taps_q[1:0], rx_in};
  end

  always_ff @(posedge clk) begin
    if (rst) taps_q <= 3'b000;
    else     taps_q <= taps_d;
  end

  assign vote       = (taps_q[0] & taps_q[1]) | (taps_q[0] & taps_q[2]) | (taps_q[1] & taps_q[2]);
  assign vote_valid = dec_en;
endmodule

// File: rtl/uart_rx_frame_engine.sv
// rtl/uart_rx_frame_engine.sv - oversampled UART receive frame engine with parity, stop and break checks
module uart_rx_frame_engine
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int PRESC_W = 6,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic [LEN_W-1:0]   cfg_data_len,
  input  logic               cfg_par_en,
  input  logic               cfg_par_odd,
  input  logic               cfg_stop2,
  uart_rx_frame_engine_if.master frame
);
  rx_state_e          state_q, state_d;
  rx_cfg_t            cfg_q, cfg_d;
  logic [PRESC_W-1:0] presc_q, presc_d, edge_cnt_q, edge_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d, bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d, p_data_q, p_data_d;
  logic               par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;

  logic [PRESC_W-1:0] last_edge, half_p2, dec_pt, tap_lo;
  logic               active, bit_end, tap_en, dec_en, vote, vote_valid;
  logic               last_stop, commit, ferr_now;

  // With prescale 4 the nominal decision point falls past the bit end, so it is pulled back to P-1.
  assign last_edge = presc_q - PRESC_W'(1);
  assign half_p2   = (presc_q >> 1) + PRESC_W'(2);
  assign dec_pt    = (half_p2 > last_edge) ? last_edge : half_p2;
  assign tap_lo    = dec_pt - PRESC_W'(3);

  assign active    = state_q inside {START, DATA, PARITY, STOP};
  assign bit_end   = active && (edge_cnt_q == last_edge);
  assign tap_en    = active && (edge_cnt_q >= tap_lo) && (edge_cnt_q < dec_pt);
  assign dec_en    = active && (edge_cnt_q == dec_pt);

  uart_rx_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .tap_en     (tap_en),
    .dec_en     (dec_en),
    .vote       (vote),
    .vote_valid (vote_valid)
  );

  assign last_stop = (bit_cnt_q == {{(LEN_W-1){1'b0}}, cfg_q.stop2});
  assign commit    = (state_q == STOP) && vote_valid && last_stop;
  assign ferr_now  = ferr_q | ~vote;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_in) state_d = START;
      START: begin
        if (vote_valid && vote) state_d = IDLE;
        else if (bit_end)       state_d = DATA;
      end
      DATA:   if (bit_end && (bit_cnt_q == len_q - LEN_W'(1))) state_d = cfg_q.par_en ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (commit) state_d = (ferr_now && !rx_in) ? BREAK : IDLE;
      BREAK:  if (rx_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame.p_data       = commit ? shreg_q : p_data_q;
    frame.data_valid   = commit && !perr_q && !ferr_now;
    frame.par_err      = commit && perr_q;
    frame.frm_err      = commit && ferr_now;
    frame.start_glitch = (state_q == START) && vote_valid && vote;
    frame.break_det    = (state_q == BREAK);
    frame.busy         = (state_q != IDLE);
  end

  always_comb begin
    cfg_d      = cfg_q;
    presc_d    = presc_q;
    len_d      = len_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    p_data_d   = p_data_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    if (!active) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      if (state_q == IDLE) begin
        shreg_d = '0;
        par_d   = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (state_d == START) begin
          cfg_d   = '{par_en: cfg_par_en, par_odd: cfg_par_odd, stop2: cfg_stop2};
          presc_d = (cfg_prescale < PRESC_W'(MIN_PRESC)) ? PRESC_W'(MIN_PRESC) : cfg_prescale;
          len_d   = (cfg_data_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) :
                    (cfg_data_len > LEN_W'(DATA_W))  ? LEN_W'(DATA_W)  : cfg_data_len;
        end
      end
    end else begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESC_W'(1);
      if (state_d != state_q) bit_cnt_d = '0;
      else if (bit_end)       bit_cnt_d = bit_cnt_q + LEN_W'(1);
      if (vote_valid) begin
        case (state_q)
          DATA: begin
            shreg_d[bit_cnt_q] = vote;
            par_d              = par_q ^ vote;
          end
          PARITY:  if (vote != (par_q ^ cfg_q.par_odd)) perr_d = 1'b1;
          STOP:    if (!vote) ferr_d = 1'b1;
          default: ;
        endcase
      end
      if (commit) p_data_d = shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      presc_q    <= '0;
      len_q      <= '0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      p_data_q   <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      presc_q    <= presc_d;
      len_q      <= len_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      p_data_q   <= p_data_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// tb/tb_uart_rx_frame_engine.sv - directed self-checking bench for the UART RX frame engine
module tb_uart_rx_frame_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] cfg_prescale = 6'd8;
  logic [3:0] cfg_data_len = 4'd8;
  logic       cfg_par_en = 1'b0;
  logic       cfg_par_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;

  int errors = 0;
  int checks = 0;

  int dv_cnt = 0, perr_cnt = 0, ferr_cnt = 0, glitch_cnt = 0;
  logic [8:0] dv_log [64];
  logic [8:0] commit_data = 9'h0;

  uart_rx_frame_engine_if #(.DATA_W(9)) frame_if ();

  uart_rx_frame_engine #(.DATA_W(9), .PRESC_W(6), .LEN_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .cfg_prescale (cfg_prescale),
    .cfg_data_len (cfg_data_len),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_odd  (cfg_par_odd),
    .cfg_stop2    (cfg_stop2),
    .frame        (frame_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_if.data_valid) begin
      dv_log[dv_cnt[5:0]] = frame_if.p_data;
      dv_cnt = dv_cnt + 1;
    end
    if (frame_if.data_valid || frame_if.par_err || frame_if.frm_err) commit_data = frame_if.p_data;
    if (frame_if.par_err)      perr_cnt = perr_cnt + 1;
    if (frame_if.frm_err)      ferr_cnt = ferr_cnt + 1;
    if (frame_if.start_glitch) glitch_cnt = glitch_cnt + 1;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input bit v, input int n);
    rx_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int presc, input int len, input bit pe, input bit po, input bit s2);
    cfg_prescale = 6'(presc);
    cfg_data_len = 4'(len);
    cfg_par_en   = pe;
    cfg_par_odd  = po;
    cfg_stop2    = s2;
  endtask

  task automatic send_frame(input logic [8:0] d, input int len, input int presc,
                            input bit pe, input bit pbit, input bit s2, input bit st0, input bit st1);
    drive_bit(1'b0, presc);
    for (int i = 0; i < len; i++) drive_bit(d[i], presc);
    if (pe) drive_bit(pbit, presc);
    drive_bit(st0, presc);
    if (s2) drive_bit(st1, presc);
    rx_in = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int dv0, pe0, fe0, gl0;
  task automatic snap();
    @(negedge clk);
    dv0 = dv_cnt; pe0 = perr_cnt; fe0 = ferr_cnt; gl0 = glitch_cnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    wait_cycles(3);
    @(negedge clk);
    check_eq("reset_p_data", frame_if.p_data, 0);
    check_eq("reset_busy", frame_if.busy, 0);
    check_eq("reset_break", frame_if.break_det, 0);
    check_eq("reset_valid", frame_if.data_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(4);

    // 8N1, prescale 8, 0xA5
    set_cfg(8, 8, 0, 0, 0);
    snap();
    send_frame(9'h0A5, 8, 8, 0, 0, 0, 1, 1);
    wait_cycles(16);
    @(negedge clk);
    check_eq("a5_valid_cnt", dv_cnt - dv0, 1);
    check_eq("a5_data", dv_log[dv0[5:0]], 9'h0A5);
    check_eq("a5_par_err", perr_cnt - pe0, 0);
    check_eq("a5_frm_err", ferr_cnt - fe0, 0);
    check_eq("a5_busy", frame_if.busy, 0);

    // 7E1, prescale 16, 0x41 with wrong parity bit 1
    set_cfg(16, 7, 1, 0, 0);
    snap();
    send_frame(9'h041, 7, 16, 1, 1, 0, 1, 1);
    wait_cycles(32);
    @(negedge clk);
    check_eq("7e1_par_err", perr_cnt - pe0, 1);
    check_eq("7e1_valid_cnt", dv_cnt - dv0, 0);
    check_eq("7e1_p_data", commit_data, 9'h041);
    check_eq("7e1_frm_err", ferr_cnt - fe0, 0);

    // short low pulse, prescale 16
    set_cfg(16, 8, 0, 0, 0);
    snap();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 48);
    @(negedge clk);
    check_eq("glitch_cnt", glitch_cnt - gl0, 1);
    check_eq("glitch_valid", dv_cnt - dv0, 0);
    check_eq("glitch_busy", frame_if.busy, 0);

    // 9O2, prescale 10, 0x1C3, correct parity 0
    set_cfg(10, 9, 1, 1, 1);
    snap();
    send_frame(9'h1C3, 9, 10, 1, 0, 1, 1, 1);
    wait_cycles(20);
    @(negedge clk);
    check_eq("9o2_valid_cnt", dv_cnt - dv0, 1);
    check_eq("9o2_data", dv_log[dv0[5:0]], 9'h1C3);
    check_eq("9o2_par_err", perr_cnt - pe0, 0);

    // same, second stop bit 0
    snap();
    send_frame(9'h1C3, 9, 10, 1, 0, 1, 1, 0);
    wait_cycles(20);
    @(negedge clk);
    check_eq("9o2_stop2_frm_err", ferr_cnt - fe0, 1);
    check_eq("9o2_stop2_valid", dv_cnt - dv0, 0);
    check_eq("9o2_stop2_p_data", commit_data, 9'h1C3);
    check_eq("9o2_stop2_busy", frame_if.busy, 0);

    // line low for 30 bit times, prescale 8
    set_cfg(8, 8, 0, 0, 0);
    snap();
    drive_bit(1'b0, 240);
    @(negedge clk);
    check_eq("brk_frm_err", ferr_cnt - fe0, 1);
    check_eq("brk_level", frame_if.break_det, 1);
    check_eq("brk_p_data", commit_data, 0);
    @(posedge clk);
    #1;
    drive_bit(1'b1, 2);
    @(negedge clk);
    check_eq("brk_released", frame_if.break_det, 0);
    check_eq("brk_busy", frame_if.busy, 0);
    wait_cycles(24);
    @(negedge clk);
    check_eq("brk_no_frame", dv_cnt - dv0, 0);
    check_eq("brk_no_glitch", glitch_cnt - gl0, 0);

    // back-to-back 8N1 at prescale 16
    set_cfg(16, 8, 0, 0, 0);
    snap();
    send_frame(9'h055, 8, 16, 0, 0, 0, 1, 1);
    send_frame(9'h03C, 8, 16, 0, 0, 0, 1, 1);
    wait_cycles(32);
    @(negedge clk);
    check_eq("b2b_valid_cnt", dv_cnt - dv0, 2);
    check_eq("b2b_first", dv_log[dv0[5:0]], 9'h055);
    check_eq("b2b_second", dv_log[6'(dv0 + 1)], 9'h03C);

    // reset mid-frame, then a clean frame
    set_cfg(8, 8, 0, 0, 0);
    snap();
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 14);
    rst = 1'b1;
    wait_cycles(1);
    @(negedge clk);
    check_eq("rst_mid_busy", frame_if.busy, 0);
    check_eq("rst_mid_p_data", frame_if.p_data, 0);
    check_eq("rst_mid_errs", frame_if.par_err | frame_if.frm_err | frame_if.data_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_bit(1'b1, 96);
    @(negedge clk);
    check_eq("rst_mid_no_frame", (dv_cnt - dv0) + (ferr_cnt - fe0) + (perr_cnt - pe0), 0);
    snap();
    send_frame(9'h096, 8, 8, 0, 0, 0, 1, 1);
    wait_cycles(16);
    @(negedge clk);
    check_eq("post_rst_valid", dv_cnt - dv0, 1);
    check_eq("post_rst_data", dv_log[dv0[5:0]], 9'h096);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_engine.md
Name: uart_rx_frame_engine

Overview:
- Parametrised UART receive frame engine: oversampled start detect, majority-vote sampling, LSB-first deserialisation, parity and stop checks, and frame delivery.
- Generalises the existing RX controller:
  - runtime data length, parity type and 1/2 stop bits;
  - internal edge/bit counters;
  - back-to-back frames with no idle gap;
  - break detection.
- Sits between the rx pin synchroniser and the RX FIFO/register interface.

Parameters:
- DATA_W, 9, maximum data bits per frame (legal 5..9).
- PRESC_W, 6, width of the prescale input.
- LEN_W, 4, width of cfg_data_len.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_in  in  1  serial input, already synchronised, idle high
- cfg_prescale  in  PRESC_W  oversampling ratio, legal 4..2^PRESC_W-1
- cfg_data_len  in  LEN_W  data bits per frame, legal 5..DATA_W
- cfg_par_en  in  1  parity bit present
- cfg_par_odd  in  1  1 = odd parity, 0 = even parity
- cfg_stop2  in  1  two stop bits
- p_data  out  DATA_W  received word, right-aligned, unused upper bits 0
- data_valid  out  1  one-cycle pulse, p_data valid
- par_err  out  1  one-cycle pulse, parity mismatch
- frm_err  out  1  one-cycle pulse, stop bit sampled 0
- start_glitch  out  1  one-cycle pulse, false start rejected
- break_det  out  1  level, high while in BREAK
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: the one clock is clk; reset is synchronous and active-high on rst. On rst high at a clock edge:
  - state = IDLE, all counters 0;
  - p_data = 0, all pulses and levels 0;
  - this applies mid-frame too: the partial frame is discarded with no flags.
- Config capture: all cfg_* inputs are captured into shadow registers on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- Timing:
  - edge_cnt runs 0..P-1 per bit, with P = captured prescale and M = P>>1;
  - samples are taken at edge_cnt M-1, M, M+1;
  - the majority vote is valid at edge_cnt == M+2 (the "decision point");
  - the bit ends at edge_cnt == P-1, where edge_cnt wraps to 0 and bit_cnt increments.
- IDLE:
  - rx_in == 0 -> START, edge_cnt = 0 on the next cycle.
- START:
  - vote 1 at the decision point -> pulse start_glitch, go to IDLE;
  - otherwise, at end of bit -> DATA, bit_cnt = 0.
- DATA:
  - at each decision point, shift the vote into position bit_cnt (LSB first) and fold it into running parity;
  - at end of bit with bit_cnt == len-1 -> PARITY if par_en, else STOP.
- PARITY:
  - at the decision point, expected bit = XOR(data) XOR par_odd;
  - on mismatch, set the internal perr flag;
  - at end of bit -> STOP.
- STOP:
  - for the first stop bit when stop2 = 1: at end of bit -> second stop bit;
  - any stop bit voting 0 sets the internal ferr flag.
  - At the decision point of the last stop bit, commit in the same cycle:
    - no errors: p_data updated, data_valid = 1 for one cycle;
    - otherwise: par_err and/or frm_err pulse; p_data still updated, data_valid = 0.
  - Next state after the commit:
    - ferr set and rx_in == 0 -> BREAK;
    - otherwise -> IDLE.
  - Committing before the end of the bit allows a start edge in the second half of the stop bit to be caught.
- BREAK:
  - break_det = 1; no start detection;
  - leave to IDLE on the first cycle rx_in == 1.
- Simultaneous events: the commit pulse and the IDLE->START transition are never in the same cycle (IDLE needs one cycle).
- Illegal config (prescale < 4, data_len outside 5..DATA_W): data_len is clamped into 5..DATA_W; prescale < 4 is treated as 4.

Decomposition:
- Package uart_rx_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - constants MIN_PRESC = 4, MIN_LEN = 5;
  - struct for the captured config.
- Sub-module uart_rx_sampler:
  - 3-tap majority voter with tap enable from the edge_cnt compare;
  - outputs vote and vote_valid.
- Counters, shifter and FSM stay in the top module.

Test Plan:
- 8N1, prescale 8, frame 0xA5 -> single data_valid pulse, p_data = 0x0A5, no error pulses, busy low after commit.
- 7E1, prescale 16, data 0x41 sent with wrong parity bit 1 -> par_err pulse, data_valid = 0, p_data = 0x041.
- rx_in low for 3 cycles only, prescale 16 -> start_glitch pulse, return to IDLE, no data_valid.
- 9O2, prescale 10, data 0x1C3 with correct parity and two stop bits -> data_valid, p_data = 0x1C3; repeat with second stop bit 0 -> frm_err.
- Line held low for 30 bit times, prescale 8 -> frm_err pulse, break_det high until rx_in returns high, then busy = 0 and no spurious frame.
- Two 8N1 frames 0x55, 0x3C back-to-back with zero idle at prescale 16 -> two data_valid pulses with correct data. Separately, assert rst mid-frame -> all outputs 0, the next frame is received correctly.
